// File: rtl/knn_reuse_streamer.sv
// knn_reuse_streamer: captures the final top-K neighbour set of one query
// and replays it, one slot per cycle, at the start of the next query.
// Ports: clk/rst (sync, active high); top_k_done/top_k_entry/top_k_slot_valid
// capture side; new_query starts a replay; out_entry/out_valid/out_ready/
// out_last replay stream; replay_done, cache_valid, proto_err status.
// Optional macro KNN_REUSE_CNT_EN adds reuse_count (saturating handshake count).
module knn_reuse_streamer #(
   parameter int K       = 8,
   parameter int ENTRY_W = 64,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 top_k_done,
   input  logic [K*ENTRY_W-1:0] top_k_entry,
   input  logic [K-1:0]         top_k_slot_valid,
   input  logic                 new_query,
   output logic [ENTRY_W-1:0]   out_entry,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic                 replay_done,
   output logic                 cache_valid,
`ifdef KNN_REUSE_CNT_EN
   output logic [CNT_W-1:0]     reuse_count,
`endif
   output logic                 proto_err
);

   localparam int PW = (K > 1) ? $clog2(K) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_DONE
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [PW-1:0]      r_ptr;
   logic [PW-1:0]      w_ptr_nxt;
   logic [ENTRY_W-1:0] r_bank [K];
   logic [K-1:0]       r_slot_vld;
   logic               r_cache_valid;
   logic               r_proto_err;
   logic               w_capture;
   logic               w_cur_vld;
   logic               w_adv;
   logic               w_last_ptr;
   logic [K-1:0]       w_hi_mask;

   // Capture is refused only while a replay is in flight.
   assign w_capture  = top_k_done && (r_state != S_STREAM);
   assign w_cur_vld  = r_slot_vld[r_ptr];
   assign w_last_ptr = (r_ptr == PW'(K - 1));

   // Empty slots are skipped in one cycle; valid ones wait for out_ready.
   assign w_adv = (r_state == S_STREAM) && (!w_cur_vld || out_ready);

   // Slots strictly above the pointer; none valid means this is the last beat.
   always_comb begin
      w_hi_mask = '0;
      for (int i = 0; i < K; i++) begin
         w_hi_mask[i] = (PW'(i) > r_ptr);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      unique case (r_state)
         S_IDLE: begin
            if (new_query) begin
               w_ptr_nxt = '0;
               // A same-cycle capture counts as a cached set.
               if (r_cache_valid || top_k_done) begin
                  w_state_nxt = S_STREAM;
               end else begin
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_STREAM: begin
            if (w_adv) begin
               if (w_last_ptr) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_ptr_nxt = r_ptr + 1'b1;
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_ptr         <= '0;
         r_slot_vld    <= '0;
         r_cache_valid <= 1'b0;
         r_proto_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         if (w_capture) begin
            r_slot_vld    <= top_k_slot_valid;
            r_cache_valid <= 1'b1;
         end
         if (top_k_done && (r_state == S_STREAM)) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   // Entry storage needs no reset; the slot-valid bank gates its use.
   always_ff @(posedge clk) begin
      if (w_capture) begin
         for (int i = 0; i < K; i++) begin
            r_bank[i] <= top_k_entry[i*ENTRY_W +: ENTRY_W];
         end
      end
   end

   assign out_valid   = (r_state == S_STREAM) && w_cur_vld;
   assign out_entry   = out_valid ? r_bank[r_ptr] : '0;
   assign out_last    = out_valid && ((r_slot_vld & w_hi_mask) == '0);
   assign replay_done = (r_state == S_DONE);
   assign cache_valid = r_cache_valid;
   assign proto_err   = r_proto_err;

`ifdef KNN_REUSE_CNT_EN
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (out_valid && out_ready && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign reuse_count = r_cnt;
`endif

endmodule

// File: doc/knn_reuse_streamer.md
Name: knn_reuse_streamer

Overview:
- Holds the previous query's final top-K neighbour set.
- When a new query starts, replays those entries one per cycle toward the distance-recompute/compare path, which then feeds topK.
- Sits directly downstream of topK (`knn_buffer_out`, `topK_done`) and upstream of the parallel distance compute stage.
- Uses a valid/ready handshake so topK back-pressure stalls the replay.

Parameters:
- K, 8, number of neighbour slots captured and replayed.
- ENTRY_W, 64, width of one packed `knn_entry_t` (point index, coordinates, distance).
- CNT_W, 16, width of the optional reuse counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- top_k_done  in  1  one-cycle pulse: topK buffer is final for the current query.
- top_k_entry  in  K*ENTRY_W  topK buffer; slot i at bits [i*ENTRY_W +: ENTRY_W].
- top_k_slot_valid  in  K  per-slot occupancy from topK.
- new_query  in  1  one-cycle pulse: a new query point has been loaded.
- out_entry  out  ENTRY_W  entry being replayed.
- out_valid  out  1  out_entry is valid.
- out_ready  in  1  downstream accepts out_entry this cycle.
- out_last  out  1  out_entry is the final valid slot of this replay.
- replay_done  out  1  one-cycle pulse when replay completes or is empty.
- cache_valid  out  1  bank holds a captured set.
- proto_err  out  1  sticky: top_k_done arrived during STREAM.
- reuse_count  out  CNT_W  present only with the optional feature.

Behaviour:
- Reset (synchronous, rst=1 at the clock edge):
  - All outputs go to 0; bank contents are don't-care; slot-valid bank is cleared.
  - State goes to IDLE; slot pointer goes to 0.
  - rst mid-STREAM aborts the replay with no replay_done.
- Capture:
  - On top_k_done in IDLE or DONE, all K entries and their valid bits are latched in parallel on that edge.
  - cache_valid is set to 1 from the next cycle.
  - If every latched slot is invalid, cache_valid remains 1; the replay is then empty.
- State machine: IDLE -> STREAM -> DONE -> IDLE.
- IDLE:
  - new_query with cache_valid=0 -> DONE (empty replay): replay_done pulses at t+1, no out_valid.
  - new_query with cache_valid=1 -> STREAM, pointer=0.
  - Simultaneous top_k_done and new_query in IDLE: capture first; the replay uses the newly captured set (cache_valid is treated as 1).
- STREAM:
  - Each cycle the pointer examines slot p.
  - If slot p is invalid: out_valid=0 and the pointer advances (one cycle per skipped slot).
  - If slot p is valid: out_valid=1 and out_entry=bank[p]; both are held stable until out_ready=1, then the pointer advances.
  - out_last=1 when p is the highest-indexed valid slot.
  - After the transfer (or skip) of slot K-1 -> DONE.
  - First out_valid for slot 0 is at t+1 after new_query.
  - Full replay of all-valid slots with out_ready tied high takes K cycles.
- DONE:
  - replay_done=1 for exactly this cycle, then -> IDLE.
  - new_query in DONE is ignored.
  - top_k_done in DONE captures normally.
- Protocol errors:
  - top_k_done during STREAM is ignored (bank unchanged) and sets proto_err.
  - new_query during STREAM is ignored.
  - proto_err clears only on rst.
- No arithmetic on entries; they are passed through bit-exact.

Optional Feature:
- Macro: KNN_REUSE_CNT_EN.
- Defined:
  - reuse_count increments by 1 on every out_valid&&out_ready handshake.
  - It saturates at 2^CNT_W-1 and resets to 0.
- Undefined:
  - The reuse_count port and its counter do not exist.
  - All other behaviour is identical.

Test Plan:
- Empty-cache start: reset, then new_query at cycle 5 with no prior capture -> replay_done=1 at cycle 6; out_valid stays 0; cache_valid=0.
- Full replay:
  - Stimulus: K=8, all slots valid, entries 0x10..0x17, top_k_done at cycle 3, new_query at cycle 5, out_ready=1.
  - Response: out_entry 0x10..0x17 on cycles 6..13; out_last at cycle 13; replay_done at cycle 14.
- Sparse slots with back-pressure:
  - Stimulus: valid mask 8'b0010_0101; out_ready low on the first cycle out_valid is high.
  - Response: slot0 is held 2 cycles; then slot2 and slot5 are emitted; out_last accompanies slot5; gaps appear for the invalid slots.
- Simultaneous capture and query: top_k_done and new_query in the same cycle in IDLE with entries 0xA0.. -> replay emits the new 0xA0.. values, not the previous set.
- Collision and abort:
  - top_k_done mid-STREAM -> proto_err=1 and the replay continues with the old data.
  - rst asserted at replay cycle 3 -> all outputs 0 next cycle, no replay_done; proto_err=0.
- KNN_REUSE_CNT_EN:
  - Stimulus: run two full replays of 8 slots.
  - Response: reuse_count=16; with CNT_W=4 it saturates at 15.
